// File: rtl/avl_reg_pkg.sv
// Shared constants and the byte-merge helper for the Avalon-MM register bank.
// The merge works at a fixed maximum width; callers size-cast in and out.
package avl_reg_pkg;

  localparam int CTRL_START_BIT = 0;
  localparam int STAT_DONE_BIT  = 0;
  localparam int STAT_BUSY_BIT  = 1;

  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int k = 0; k < MAX_BE_W; k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/avl_byte_reg.sv
// One DATA_W register with byte-enable bus write, full-width hardware load
// and synchronous reset. A hardware load takes priority over a bus write.
module avl_byte_reg
  import avl_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                ld_en,
  input  logic [DATA_W-1:0]   ld_data,
  output logic [DATA_W-1:0]   q
);

  // NOTE: state is updated with <= only, so every register in the bank
  // samples the same pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q <= '0;
    end else if (ld_en) begin
      q <= ld_data;
    end else if (wr_en) begin
      q <= DATA_W'(merge_bytes(MAX_DATA_W'(q), MAX_DATA_W'(wr_data),
                               MAX_BE_W'(byte_en)));
    end
  end

endmodule

// File: rtl/avl_reg_bank.sv
// Avalon-MM slave register bank: byte-merged writes, registered reads, hardware
// read-only registers and a CTRL/STATUS start/busy/done accelerator handshake.
module avl_reg_bank
  import avl_reg_pkg::*;
#(
  parameter int                  NUM_REGS    = 16,
  parameter int                  ADDR_W      = 4,
  parameter int                  DATA_W      = 32,
  parameter logic [NUM_REGS-1:0] RO_MASK     = 16'h0002,
  parameter int                  CTRL_ADDR   = 0,
  parameter int                  STATUS_ADDR = 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       AVL_CS,
  input  logic                       AVL_READ,
  input  logic                       AVL_WRITE,
  input  logic [ADDR_W-1:0]          AVL_ADDR,
  input  logic [DATA_W/8-1:0]        AVL_BYTE_EN,
  input  logic [DATA_W-1:0]          AVL_WRITEDATA,
  output logic [DATA_W-1:0]          AVL_READDATA,
  output logic                       AVL_READDATAVALID,
  input  logic [NUM_REGS-1:0]        HW_WE,
  input  logic [NUM_REGS*DATA_W-1:0] HW_DATA,
  input  logic                       DONE_IN,
  output logic                       START_OUT,
  output logic [NUM_REGS*DATA_W-1:0] REG_OUT
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] ctrl_wdata;
  logic [DATA_W-1:0] rd_mux;
  logic acc_wr, acc_rd;
  logic wr_ctrl, wr_status;
  logic busy, done, busy_nxt, done_nxt;
  logic start_acc, w1c;

  assign acc_wr    = AVL_CS & AVL_WRITE;
  assign acc_rd    = AVL_CS & AVL_READ;
  assign wr_ctrl   = acc_wr && (AVL_ADDR == ADDR_W'(CTRL_ADDR));
  assign wr_status = acc_wr && (AVL_ADDR == ADDR_W'(STATUS_ADDR));

  assign busy = regs[STATUS_ADDR][STAT_BUSY_BIT];
  assign done = regs[STATUS_ADDR][STAT_DONE_BIT];

  assign start_acc = wr_ctrl & AVL_BYTE_EN[0] & AVL_WRITEDATA[CTRL_START_BIT] & ~busy;
  assign w1c       = wr_status & AVL_BYTE_EN[0] & AVL_WRITEDATA[STAT_DONE_BIT];

  // START is self-clearing: the stored CTRL bit always reads back as 0.
  always_comb begin
    ctrl_wdata                 = AVL_WRITEDATA;
    ctrl_wdata[CTRL_START_BIT] = 1'b0;
  end

  // Accepted start beats a same-cycle completion; otherwise completion beats W1C.
  always_comb begin
    busy_nxt = busy;
    done_nxt = done;
    if (start_acc) begin
      busy_nxt = 1'b1;
      done_nxt = 1'b0;
    end else begin
      if (w1c) done_nxt = 1'b0;
      if (DONE_IN) begin
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic              sel;
    logic [DATA_W-1:0] hw_word;
    assign sel     = acc_wr && (AVL_ADDR == ADDR_W'(i));
    assign hw_word = HW_DATA[i*DATA_W +: DATA_W];

    if (i == STATUS_ADDR) begin : g_status
      // STATUS reloads every cycle: handshake bits from the FSM, upper bits from HW.
      logic [DATA_W-1:0] st_next;
      always_comb begin
        st_next                = HW_WE[i] ? hw_word : regs[i];
        st_next[STAT_BUSY_BIT] = busy_nxt;
        st_next[STAT_DONE_BIT] = done_nxt;
      end
      avl_byte_reg #(.DATA_W(DATA_W)) u_reg (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (1'b0),
        .byte_en (AVL_BYTE_EN),
        .wr_data (AVL_WRITEDATA),
        .ld_en   (1'b1),
        .ld_data (st_next),
        .q       (regs[i])
      );
    end else begin : g_plain
      avl_byte_reg #(.DATA_W(DATA_W)) u_reg (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (sel & ~RO_MASK[i]),
        .byte_en (AVL_BYTE_EN),
        .wr_data ((i == CTRL_ADDR) ? ctrl_wdata : AVL_WRITEDATA),
        .ld_en   (HW_WE[i] & RO_MASK[i]),
        .ld_data (hw_word),
        .q       (regs[i])
      );
    end

    assign REG_OUT[i*DATA_W +: DATA_W] = regs[i];
  end

  // NOTE: rd_mux gets a default before the loop so no latch is inferred and
  // out-of-range addresses read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (AVL_ADDR == ADDR_W'(i)) rd_mux = regs[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      AVL_READDATA      <= '0;
      AVL_READDATAVALID <= 1'b0;
      START_OUT         <= 1'b0;
    end else begin
      START_OUT         <= start_acc;
      AVL_READDATAVALID <= acc_rd;
      if (acc_rd) AVL_READDATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_avl_reg_bank.sv
// Self-checking bench for avl_reg_bank: directed cases plus random traffic,
// read data checked by a scoreboard queue against a behavioural model.
module tb_avl_reg_bank;

  localparam int              N      = 12;
  localparam int              W      = 32;
  localparam int              CTRL_I = 0;
  localparam int              STAT_I = 1;
  localparam logic [N-1:0]    RO     = 12'h402;

  typedef enum {S_IDLE, S_BUSY, S_DONE} hs_t;
  typedef struct {
    logic [W-1:0] data;
    int           due;
  } rd_exp_t;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           AVL_CS, AVL_READ, AVL_WRITE;
  logic [3:0]     AVL_ADDR;
  logic [3:0]     AVL_BYTE_EN;
  logic [W-1:0]   AVL_WRITEDATA;
  logic [W-1:0]   AVL_READDATA;
  logic           AVL_READDATAVALID;
  logic [N-1:0]   HW_WE;
  logic [N*W-1:0] HW_DATA;
  logic           DONE_IN;
  logic           START_OUT;
  logic [N*W-1:0] REG_OUT;

  avl_reg_bank #(
    .NUM_REGS(N), .ADDR_W(4), .DATA_W(W), .RO_MASK(RO),
    .CTRL_ADDR(CTRL_I), .STATUS_ADDR(STAT_I)
  ) dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .AVL_READDATAVALID(AVL_READDATAVALID), .HW_WE(HW_WE), .HW_DATA(HW_DATA),
    .DONE_IN(DONE_IN), .START_OUT(START_OUT), .REG_OUT(REG_OUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: plain register array plus a three-state handshake.
  logic [W-1:0] m_regs [N];
  logic [29:0]  m_hi;
  hs_t          m_state;
  logic         exp_start;
  rd_exp_t      exp_q [$];

  function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                         input logic [3:0] be);
    logic [W-1:0] r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic logic [W-1:0] model_reg(input int i);
    if (i == STAT_I) return {m_hi, m_state == S_BUSY, m_state == S_DONE};
    return m_regs[i];
  endfunction

  task automatic model_step();
    logic         start_req, w1c;
    logic [W-1:0] nv;
    int           a;
    exp_start = 1'b0;
    if (RESET) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_hi    = '0;
      m_state = S_IDLE;
      return;
    end
    start_req = 1'b0;
    w1c       = 1'b0;
    a         = int'(AVL_ADDR);
    if (AVL_CS && AVL_WRITE && a < N) begin
      if (a == CTRL_I) begin
        nv        = merge(m_regs[a], AVL_WRITEDATA, AVL_BYTE_EN);
        nv[0]     = 1'b0;
        m_regs[a] = nv;
        start_req = AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
      end else if (a == STAT_I) begin
        w1c = AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
      end else if (!RO[a]) begin
        m_regs[a] = merge(m_regs[a], AVL_WRITEDATA, AVL_BYTE_EN);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (HW_WE[i] && RO[i]) begin
        if (i == STAT_I) m_hi = HW_DATA[i*W+2 +: 30];
        else             m_regs[i] = HW_DATA[i*W +: W];
      end
    end
    if (start_req && m_state != S_BUSY) begin
      m_state   = S_BUSY;
      exp_start = 1'b1;
    end else if (DONE_IN) begin
      m_state = S_DONE;
    end else if (w1c && m_state == S_DONE) begin
      m_state = S_IDLE;
    end
  endtask

  task automatic idle_inputs();
    RESET = 0; AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = '0;
    AVL_BYTE_EN = '0; AVL_WRITEDATA = '0; HW_WE = '0; HW_DATA = '0; DONE_IN = 0;
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic tick();
    rd_exp_t e;
    if (AVL_CS && AVL_READ && !RESET) begin
      e.data = (int'(AVL_ADDR) < N) ? model_reg(int'(AVL_ADDR)) : '0;
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    model_step();
    @(negedge CLK);
    check("start_out", 32'(START_OUT), 32'(exp_start));
    for (int i = 0; i < N; i++)
      check($sformatf("reg_out[%0d]", i), REG_OUT[i*W +: W], model_reg(i));
    idle_inputs();
  endtask

  task automatic do_wr(input int a, input logic [3:0] be, input logic [W-1:0] d);
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 4'(a); AVL_BYTE_EN = be; AVL_WRITEDATA = d;
    tick();
  endtask

  task automatic do_rd(input int a);
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 4'(a);
    tick();
  endtask

  // Monitor: every readdatavalid pops the oldest expected read.
  always @(negedge CLK) begin
    rd_exp_t e;
    if (AVL_READDATAVALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rd_latency", 32'(cyc), 32'(e.due));
        check("rd_data", AVL_READDATA, e.data);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      check("rd_valid_missing", 32'(AVL_READDATAVALID), 32'd1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    @(negedge CLK);
    RESET = 1; tick();
    RESET = 1; tick();
    check("valid_after_reset", 32'(AVL_READDATAVALID), 32'd0);
    check("rdata_after_reset", AVL_READDATA, 32'h0);

    // Partial byte write then read back.
    do_wr(5, 4'b0101, 32'hDEADBEEF);
    check("reg5_merge", REG_OUT[5*W +: W], 32'h00AD00EF);
    do_rd(5);

    // Writes to RO STATUS and to an unmapped address are dropped.
    do_wr(STAT_I, 4'hF, 32'h12345678);
    do_wr(15, 4'hF, 32'h12345678);
    do_rd(15);
    do_wr(7, 4'h0, 32'hFFFFFFFF);

    // Start handshake, second start while busy is ignored.
    do_wr(CTRL_I, 4'h1, 32'h1);
    check("start_pulse", 32'(START_OUT), 32'd1);
    do_rd(STAT_I);
    do_rd(CTRL_I);
    check("status_busy", REG_OUT[STAT_I*W +: W], 32'h2);
    do_wr(CTRL_I, 4'h1, 32'h1);
    check("no_start_busy", 32'(START_OUT), 32'd0);

    // Completion, W1C racing DONE_IN, then plain W1C.
    DONE_IN = 1; tick();
    check("status_done", REG_OUT[STAT_I*W +: W], 32'h1);
    DONE_IN = 1; do_wr(STAT_I, 4'h1, 32'h1);
    check("done_beats_w1c", REG_OUT[STAT_I*W +: W], 32'h1);
    do_wr(STAT_I, 4'h1, 32'h1);
    check("w1c_clears", REG_OUT[STAT_I*W +: W], 32'h0);

    // Read and write of the same register in one cycle.
    do_wr(3, 4'hF, 32'h11111111);
    AVL_READ = 1; do_wr(3, 4'hF, 32'hAAAA5555);
    do_rd(3);

    // HW loads: honoured on RO regs (incl. STATUS upper bits), ignored on RW.
    HW_WE = 12'h422; HW_DATA[10*W +: W] = 32'hCAFEF00D;
    HW_DATA[5*W +: W] = 32'h0BADBAD0; HW_DATA[STAT_I*W +: W] = 32'hFFFFFFFF;
    tick();
    do_rd(10);

    // Reset in the middle of a busy operation with a read in flight.
    do_wr(CTRL_I, 4'h1, 32'h1);
    RESET = 1; AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 4'd10; tick();
    check("status_after_mid_reset", REG_OUT[STAT_I*W +: W], 32'h0);
    check("valid_dropped", 32'(AVL_READDATAVALID), 32'd0);

    // Random traffic.
    for (int t = 0; t < 600; t++) begin
      AVL_CS    = ($urandom_range(0, 9) != 0);
      AVL_READ  = $urandom_range(0, 1) == 1;
      AVL_WRITE = $urandom_range(0, 1) == 1;
      AVL_ADDR  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      AVL_BYTE_EN   = 4'($urandom);
      AVL_WRITEDATA = $urandom;
      DONE_IN = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) begin
        HW_WE = N'($urandom);
        for (int i = 0; i < N; i++) HW_DATA[i*W +: W] = $urandom;
      end
      RESET = ($urandom_range(0, 199) == 0);
      tick();
    end

    repeat (3) tick();
    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avl_reg_bank.md
Name: avl_reg_bank

Overview:
Parametrised Avalon-MM slave register bank, the successor to the fixed 16x32 register file.
- Full per-byte write merging for any AVL_BYTE_EN pattern.
- Registered reads with a valid strobe.
- Hardware-owned read-only registers.
- A CTRL/STATUS pair giving a start/busy/done handshake to an attached accelerator (AES, datapath FSM).
- Sits between the NIOS Avalon fabric and the accelerator core.

Parameters:
NUM_REGS, 16, number of DATA_W-bit registers (2..256)
ADDR_W, 4, AVL_ADDR width; NUM_REGS <= 2**ADDR_W
DATA_W, 32, register width; multiple of 8
RO_MASK, 16'h0002, bit i set: register i is bus-read-only and loaded from HW_DATA. Width NUM_REGS.
CTRL_ADDR, 0, index of the control register
STATUS_ADDR, 1, index of the status register; its RO_MASK bit must be set

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
AVL_CS  in  1  chip select
AVL_READ  in  1  read request
AVL_WRITE  in  1  write request
AVL_ADDR  in  ADDR_W  word address
AVL_BYTE_EN  in  DATA_W/8  byte enables
AVL_WRITEDATA  in  DATA_W  write data
AVL_READDATA  out  DATA_W  registered read data
AVL_READDATAVALID  out  1  high one cycle per accepted read
HW_WE  in  NUM_REGS  per-register hardware load strobe; honoured only where RO_MASK=1
HW_DATA  in  NUM_REGS*DATA_W  hardware load data, register i at slice [i*DATA_W +: DATA_W]
DONE_IN  in  1  accelerator completion pulse
START_OUT  out  1  one-cycle start pulse to accelerator
REG_OUT  out  NUM_REGS*DATA_W  live contents of all registers, same slicing as HW_DATA

Behaviour:
- Reset: CLK and RESET only; reset is synchronous and active-high. On RESET all registers, AVL_READDATA, AVL_READDATAVALID and START_OUT go to 0. RESET overrides every other event in that cycle.
- Accepted write (AVL_CS & AVL_WRITE, addr < NUM_REGS, RO_MASK[addr]=0):
  - Byte k of the register takes AVL_WRITEDATA byte k where AVL_BYTE_EN[k]=1.
  - Other bytes hold.
  - Visible on REG_OUT the next cycle.
- Ignored writes (no error response):
  - writes to RO registers
  - addr >= NUM_REGS
  - AVL_BYTE_EN = 0
- Accepted read (AVL_CS & AVL_READ):
  - AVL_READDATA is registered at the clock edge; AVL_READDATAVALID=1 the following cycle (latency 1).
  - addr >= NUM_REGS returns 0.
  - AVL_READDATA holds its last value when no read is pending.
- Read and write in the same cycle to the same address: read returns the pre-write value, and the write is performed.
- HW load: HW_WE[i] & RO_MASK[i] loads HW_DATA slice i in full. HW_WE on RW registers is ignored.
- CTRL register: bit0 START, self-clearing.
  - A write with byte 0 enabled and bit0=1 while BUSY=0 raises START_OUT for exactly one cycle, in the cycle after the write.
  - The same write sets BUSY, clears DONE, and leaves CTRL bit0 reading 0.
  - If BUSY=1, START is ignored: no pulse, BUSY/DONE unchanged. Other CTRL bits are written normally.
- STATUS register: bit0 DONE (sticky), bit1 BUSY; bits above 1 come from HW_DATA via HW_WE.
  - DONE_IN=1 sets DONE and clears BUSY.
  - Bus write to STATUS with byte 0 enabled clears each DONE bit written as 1 (W1C), despite RO_MASK.
  - DONE_IN and W1C in the same cycle: set wins, DONE=1.
  - START acceptance and DONE_IN in the same cycle: START wins, BUSY=1, DONE=0.
  - Bits 0 and 1 are never driven by HW_WE.
- Handshake state, encoded in BUSY/DONE:
  - IDLE(0,0) -start-> BUSY(1,0)
  - BUSY -DONE_IN-> COMPLETE(0,1)
  - COMPLETE -start-> BUSY
  - COMPLETE -W1C-> IDLE
  - DONE_IN in IDLE sets DONE (spurious completions are recorded).
- RESET mid-operation: returns to IDLE. A pending read's AVL_READDATAVALID is dropped.

Decomposition:
- Package avl_reg_pkg: CTRL_START_BIT=0, STAT_DONE_BIT=0, STAT_BUSY_BIT=1, and the byte-merge function merge_bytes(old, new, be).
- One sub-module: avl_byte_reg (single DATA_W register with byte-enable write, HW load port and synchronous reset), generated NUM_REGS times. CTRL and STATUS side-effect logic lives in the top.

Test Plan:
- Reset, then write 0xDEADBEEF to reg 5 with BE=4'b0101 -> reg 5 = 0x00AD00EF. Read reg 5 -> AVL_READDATAVALID high next cycle with 0x00AD00EF.
- Write 0x12345678 to STATUS (RO) and to addr 15 with NUM_REGS=12 -> neither changes. Read addr 15 -> 0.
- Write CTRL=0x1 -> START_OUT high exactly 1 cycle, STATUS reads 0x2, CTRL reads 0x0. Second write CTRL=0x1 while busy -> no pulse.
- Pulse DONE_IN -> STATUS=0x1. Write STATUS=0x1 in the same cycle as a DONE_IN pulse -> STATUS stays 0x1. Next W1C alone -> 0x0.
- Read reg 3 and write 0xAAAA5555 (BE=4'hF) to reg 3 in the same cycle with old value 0x11111111 -> readdata 0x11111111; next read 0xAAAA5555.
- Start accelerator, assert RESET for one cycle mid-busy with a read pending -> STATUS=0, START_OUT=0, no AVL_READDATAVALID, all of REG_OUT = 0.
